// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - PS/2 scan-code decoder: FIFO drain, prefix decode, key events
module ps2_kbd_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  input  logic             kbd_overflow,
  output logic             kbd_nextdata_n,
  output logic             evt_valid,
  output logic [7:0]       evt_code,
  output logic             evt_break,
  output logic             evt_ext,
  output logic             key_down,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [CNT_W-1:0] press_count,
  output logic             err_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t           state_q;
  logic [7:0]       byte_q;
  logic             ext_pend_q;
  logic             brk_pend_q;
  logic             nextdata_n_q;
  logic             evt_valid_q;
  logic [7:0]       evt_code_q;
  logic             evt_break_q;
  logic             evt_ext_q;
  logic             key_down_q;
  logic [7:0]       key_code_q;
  logic             key_ext_q;
  logic [CNT_W-1:0] press_count_q;
  logic             err_overflow_q;

  logic is_ext_d;
  logic is_brk_d;
  logic is_err_d;
  logic match_d;

  // Classify the latched byte and decide whether it repeats the held key
  always_comb begin
    is_ext_d = 1'b0;
    is_brk_d = 1'b0;
    is_err_d = 1'b0;
    match_d  = 1'b0;
    is_ext_d = (byte_q == 8'hE0);
    is_brk_d = (byte_q == 8'hF0);
    is_err_d = (byte_q == 8'h00) || (byte_q == 8'hFF);
    match_d  = key_down_q && (byte_q == key_code_q) && (ext_pend_q == key_ext_q);
  end

  // Control FSM: capture head byte, pop it while decoding, let the receiver settle
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q        <= ST_IDLE;
      byte_q         <= 8'h00;
      ext_pend_q     <= 1'b0;
      brk_pend_q     <= 1'b0;
      nextdata_n_q   <= 1'b1;
      evt_valid_q    <= 1'b0;
      evt_code_q     <= 8'h00;
      evt_break_q    <= 1'b0;
      evt_ext_q      <= 1'b0;
      key_down_q     <= 1'b0;
      key_code_q     <= 8'h00;
      key_ext_q      <= 1'b0;
      press_count_q  <= '0;
      err_overflow_q <= 1'b0;
    end else begin
      evt_valid_q    <= 1'b0;
      nextdata_n_q   <= 1'b1;
      err_overflow_q <= err_overflow_q | kbd_overflow;
      case (state_q)
        ST_IDLE: begin
          if (kbd_ready) begin
            byte_q       <= kbd_data;
            nextdata_n_q <= 1'b0;
            state_q      <= ST_POP;
          end
        end
        ST_POP: begin
          state_q <= ST_SETTLE;
          if (is_ext_d) begin
            ext_pend_q <= 1'b1;
          end else if (is_brk_d) begin
            brk_pend_q <= 1'b1;
          end else if (is_err_d) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
          end else begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            if (brk_pend_q) begin
              // Releases are always reported; only a matching one drops the held key
              evt_valid_q <= 1'b1;
              evt_code_q  <= byte_q;
              evt_break_q <= 1'b1;
              evt_ext_q   <= ext_pend_q;
              if (match_d) begin
                key_down_q <= 1'b0;
              end
            end else if (!match_d) begin
              // A press of the already-held key is typematic and is swallowed
              evt_valid_q   <= 1'b1;
              evt_code_q    <= byte_q;
              evt_break_q   <= 1'b0;
              evt_ext_q     <= ext_pend_q;
              key_down_q    <= 1'b1;
              key_code_q    <= byte_q;
              key_ext_q     <= ext_pend_q;
              press_count_q <= press_count_q + CNT_W'(1);
            end
          end
        end
        ST_SETTLE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign kbd_nextdata_n = nextdata_n_q;
  assign evt_valid      = evt_valid_q;
  assign evt_code       = evt_code_q;
  assign evt_break      = evt_break_q;
  assign evt_ext        = evt_ext_q;
  assign key_down       = key_down_q;
  assign key_code       = key_code_q;
  assign key_ext        = key_ext_q;
  assign press_count    = press_count_q;
  assign err_overflow   = err_overflow_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - self-checking bench for ps2_kbd_ctrl
module tb_ps2_kbd_ctrl;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] kbd_data = 8'h00;
  logic       kbd_ready = 1'b0;
  logic       kbd_overflow = 1'b0;
  logic       kbd_nextdata_n;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_ext;
  logic       key_down;
  logic [7:0] key_code;
  logic       key_ext;
  logic [7:0] press_count;
  logic       err_overflow;

  ps2_kbd_ctrl #(.CNT_W(8)) dut (
    .clk            (clk),
    .clrn           (clrn),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .kbd_overflow   (kbd_overflow),
    .kbd_nextdata_n (kbd_nextdata_n),
    .evt_valid      (evt_valid),
    .evt_code       (evt_code),
    .evt_break      (evt_break),
    .evt_ext        (evt_ext),
    .key_down       (key_down),
    .key_code       (key_code),
    .key_ext        (key_ext),
    .press_count    (press_count),
    .err_overflow   (err_overflow)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] fifo[$];
  logic [9:0] ev_q[$];
  logic [7:0] stim[$];
  int         pops;
  logic       prev_low;

  logic [9:0] m_ev[$];
  logic       m_down;
  logic [7:0] m_code;
  logic       m_ext;
  logic [7:0] m_cnt;

  typedef struct {
    logic [63:0] bytes;
    int          n;
    int          nev;
    logic        kd;
    logic [7:0]  kc;
    logic        ke;
    logic [7:0]  pc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  // Receiver model: one negedge step, pops on an observed low strobe
  task automatic tick();
    @(negedge clk);
    if (!kbd_nextdata_n) begin
      pops++;
      chk("pop_spacing", 32'(prev_low), 32'd0);
      chk("pop_nonempty", 32'(fifo.size() != 0), 32'd1);
      if (fifo.size() != 0) void'(fifo.pop_front());
    end
    prev_low = !kbd_nextdata_n;
    if (evt_valid) ev_q.push_back({evt_break, evt_ext, evt_code});
    kbd_ready = (fifo.size() != 0);
    kbd_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    kbd_ready = 1'b1;
    kbd_data  = fifo[0];
  endtask

  task automatic drain();
    int budget = 0;
    while (fifo.size() != 0 && budget < 200) begin
      tick();
      budget++;
    end
    if (budget >= 200) chk("drain_timeout", 32'd0, 32'd1);
    repeat (4) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    fifo.delete();
    kbd_ready = 1'b0;
    kbd_data  = 8'h00;
    tick();
    clrn = 1'b1;
    ev_q.delete();
    pops = 0;
    prev_low = 1'b0;
  endtask

  // Reference: walk the byte list applying the prefix/press/release rules
  task automatic run_model();
    logic e, b, match;
    e = 1'b0; b = 1'b0;
    m_ev.delete();
    m_down = 1'b0; m_code = 8'h00; m_ext = 1'b0; m_cnt = 8'h00;
    foreach (stim[i]) begin
      if (stim[i] == 8'hE0) e = 1'b1;
      else if (stim[i] == 8'hF0) b = 1'b1;
      else if (stim[i] == 8'h00 || stim[i] == 8'hFF) begin e = 1'b0; b = 1'b0; end
      else begin
        match = m_down && (stim[i] == m_code) && (e == m_ext);
        if (b) begin
          m_ev.push_back({1'b1, e, stim[i]});
          if (match) m_down = 1'b0;
        end else if (!match) begin
          m_ev.push_back({1'b0, e, stim[i]});
          m_down = 1'b1; m_code = stim[i]; m_ext = e; m_cnt = m_cnt + 8'd1;
        end
        e = 1'b0; b = 1'b0;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    run_model();
    chk({tag, "_ev_count"}, 32'(ev_q.size()), 32'(m_ev.size()));
    for (int i = 0; i < m_ev.size() && i < ev_q.size(); i++)
      chk({tag, "_event"}, 32'(ev_q[i]), 32'(m_ev[i]));
    chk({tag, "_key_down"}, 32'(key_down), 32'(m_down));
    chk({tag, "_key_code"}, 32'(key_code), 32'(m_code));
    chk({tag, "_key_ext"}, 32'(key_ext), 32'(m_ext));
    chk({tag, "_press_count"}, 32'(press_count), 32'(m_cnt));
    chk({tag, "_pops"}, 32'(pops), 32'(stim.size()));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] pool[7];
    pops = 0;
    prev_low = 1'b0;
    vecs[0] = '{64'h1C,             1, 1, 1'b1, 8'h1C, 1'b0, 8'd1};
    vecs[1] = '{64'h1C_F0_1C,       3, 2, 1'b0, 8'h1C, 1'b0, 8'd1};
    vecs[2] = '{64'h1B_F0_1B_1B_1B, 5, 2, 1'b0, 8'h1B, 1'b0, 8'd1};
    vecs[3] = '{64'h75_F0_E0_75_E0, 5, 2, 1'b0, 8'h75, 1'b1, 8'd1};
    vecs[4] = '{64'h1C_F0_32_1C,    4, 3, 1'b1, 8'h32, 1'b0, 8'd2};
    vecs[5] = '{64'h75_E0_F0,       3, 1, 1'b0, 8'h00, 1'b0, 8'd0};
    vecs[6] = '{64'h1C_00_E0,       3, 1, 1'b1, 8'h1C, 1'b0, 8'd1};
    pool = '{8'hE0, 8'hF0, 8'h00, 8'h1C, 8'h32, 8'h75, 8'hFF};

    // reset values
    tick();
    chk("rst_nextdata_n", 32'(kbd_nextdata_n), 32'd1);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_key_down", 32'(key_down), 32'd0);
    chk("rst_key_code", 32'(key_code), 32'd0);
    chk("rst_press_count", 32'(press_count), 32'd0);
    chk("rst_err_overflow", 32'(err_overflow), 32'd0);
    clrn = 1'b1;
    tick();

    // latency of a single byte
    do_reset();
    push(8'h1C);
    tick();
    chk("lat_pop_low", 32'(kbd_nextdata_n), 32'd0);
    chk("lat_no_evt_yet", 32'(evt_valid), 32'd0);
    tick();
    chk("lat_evt_valid", 32'(evt_valid), 32'd1);
    chk("lat_evt_code", 32'(evt_code), 32'h1C);
    chk("lat_evt_break", 32'(evt_break), 32'd0);
    chk("lat_key_down", 32'(key_down), 32'd1);
    chk("lat_press_count", 32'(press_count), 32'd1);
    chk("lat_pop_high", 32'(kbd_nextdata_n), 32'd1);
    tick();
    chk("lat_evt_single", 32'(evt_valid), 32'd0);

    // table vectors
    for (int v = 0; v < 7; v++) begin
      do_reset();
      stim.delete();
      for (int i = 0; i < vecs[v].n; i++) begin
        stim.push_back(vecs[v].bytes[8*i +: 8]);
        push(vecs[v].bytes[8*i +: 8]);
      end
      drain();
      chk($sformatf("vec%0d_ev_count", v), 32'(ev_q.size()), 32'(vecs[v].nev));
      chk($sformatf("vec%0d_key_down", v), 32'(key_down), 32'(vecs[v].kd));
      chk($sformatf("vec%0d_key_code", v), 32'(key_code), 32'(vecs[v].kc));
      chk($sformatf("vec%0d_key_ext", v), 32'(key_ext), 32'(vecs[v].ke));
      chk($sformatf("vec%0d_press_count", v), 32'(press_count), 32'(vecs[v].pc));
      compare_model($sformatf("vec%0d", v));
    end

    // pending prefix lost across reset
    do_reset();
    push(8'hF0);
    drain();
    do_reset();
    push(8'h1C);
    drain();
    chk("rstpfx_ev_count", 32'(ev_q.size()), 32'd1);
    if (ev_q.size() != 0) chk("rstpfx_break", 32'(ev_q[0][9]), 32'd0);
    chk("rstpfx_press_count", 32'(press_count), 32'd1);

    // sticky overflow
    do_reset();
    chk("ovf_clear", 32'(err_overflow), 32'd0);
    kbd_overflow = 1'b1;
    tick();
    kbd_overflow = 1'b0;
    tick();
    chk("ovf_set", 32'(err_overflow), 32'd1);
    repeat (6) tick();
    chk("ovf_sticky", 32'(err_overflow), 32'd1);
    do_reset();
    chk("ovf_reset", 32'(err_overflow), 32'd0);

    // press counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      push((i % 2 == 0) ? 8'h1C : 8'h32);
      drain();
    end
    chk("wrap_zero", 32'(press_count), 32'd0);
    push(8'h75);
    drain();
    chk("wrap_one", 32'(press_count), 32'd1);

    // randomized streams against the model
    for (int r = 0; r < 25; r++) begin
      int len;
      do_reset();
      stim.delete();
      len = $urandom_range(8, 1);
      for (int i = 0; i < len; i++) begin
        logic [7:0] b;
        b = pool[$urandom_range(6, 0)];
        stim.push_back(b);
        push(b);
      end
      drain();
      compare_model($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

Scan-code controller that sits behind the PS/2 receiver. It drains the receiver's 8-entry byte FIFO through its `ready` / `nextdata_n` handshake and decodes the prefix bytes `0xE0` (extended) and `0xF0` (break). It turns the byte stream into single-cycle key events, suppresses typematic repeats, and tracks the currently held key plus a press counter for the display/CPU side.

## Interface
- `CNT_W`, 8, width of the press counter.

- `clk`  in  1  system clock; same clock as the receiver.
- `clrn`  in  1  reset; one clock, asynchronous, active-low.
- `kbd_data`  in  8  byte at the receiver FIFO head; valid while `kbd_ready`=1.
- `kbd_ready`  in  1  receiver FIFO non-empty.
- `kbd_overflow`  in  1  receiver FIFO overflow flag.
- `kbd_nextdata_n`  out  1  active-low pop strobe to the receiver; exactly one cycle low per byte.
- `evt_valid`  out  1  one-cycle pulse, one per decoded key event.
- `evt_code`  out  8  scan code of the event; valid with `evt_valid`.
- `evt_break`  out  1  1 = release event, 0 = press; valid with `evt_valid`.
- `evt_ext`  out  1  event was `0xE0`-prefixed; valid with `evt_valid`.
- `key_down`  out  1  a key is currently held.
- `key_code`  out  8  code of the last pressed key; held after release.
- `key_ext`  out  1  extended flag of `key_code`.
- `press_count`  out  `CNT_W`  count of distinct presses, modulo 2^`CNT_W`.
- `err_overflow`  out  1  sticky; set when `kbd_overflow`=1 is seen.

## Operation
- FSM states:
  - IDLE: if `kbd_ready`=1, latch `kbd_data` into `byte_r` and go to POP. Otherwise stay.
  - POP: drive `kbd_nextdata_n`=0, decode `byte_r`, update registers, go to SETTLE.
  - SETTLE: `kbd_nextdata_n`=1. Wait one cycle for the receiver's `ready`/`data` to reflect the pop, then go to IDLE.
- Decode in POP, first match wins:
  - `0xE0`: set `ext_pend`. No event.
  - `0xF0`: set `brk_pend`. No event.
  - `0x00` or `0xFF` (keyboard error codes): discard the byte and clear both pending flags. No event.
  - Any other byte: this is a code byte. Let `ext = ext_pend`, `brk = brk_pend`, and `match = key_down & (byte_r == key_code) & (ext == key_ext)`. Clear both pending flags after decoding.
- Code byte, `brk`=0, `match`=1: typematic repeat. No event and no counter change.
- Code byte, `brk`=0, `match`=0:
  - Emit a press event.
  - `key_down` <= 1, `key_code` <= `byte_r`, `key_ext` <= `ext`.
  - `press_count` <= `press_count` + 1, wrapping.
- Code byte, `brk`=1:
  - Always emit a release event.
  - If `match`=1, `key_down` <= 0. Otherwise `key_down` is unchanged.
  - `key_code` and `key_ext` are unchanged.
- An event drives `evt_valid`=1 with `evt_code`=`byte_r`, `evt_break`=`brk`, `evt_ext`=`ext`.
- `err_overflow` <= `err_overflow` | `kbd_overflow`, sampled every cycle in every state.
- Prefix order: `E0 F0 xx` and `F0 E0 xx` both decode as extended release. A repeated prefix is idempotent.

## Timing
- All outputs are registered. Reset values:
  - `kbd_nextdata_n`=1.
  - All other outputs 0.
  - FSM in IDLE; `ext_pend`=`brk_pend`=0.
- Throughput: one FIFO byte per 3 cycles (IDLE→POP→SETTLE).
- Latency: `kbd_ready` first seen high in cycle N (IDLE).
  - `kbd_nextdata_n`=0 during N+1.
  - `evt_valid` is high during N+2 (registered at the end of POP).
  - `key_*` and `press_count` update at the same edge as `evt_valid`.
- `kbd_nextdata_n` is never low in two consecutive cycles. It is never low unless `kbd_ready` was 1 at the preceding capture.
- `kbd_ready` dropping during POP or SETTLE has no effect. The byte is already latched.
- `clrn` low at any time:
  - Outputs go to reset values immediately.
  - A partially decoded prefix sequence is lost.
  - The receiver FIFO is not popped.
- `press_count` wraps from 2^`CNT_W`-1 to 0 with no flag.
- `err_overflow` clears only on reset.

## Test plan
- Bytes `1C` in FIFO, consumer idle → one `kbd_nextdata_n` low pulse. Then `evt_valid` with code=`1C`, break=0, ext=0; `key_down`=1, `key_code`=`1C`, `press_count`=1.
- Bytes `1C F0 1C` → exactly 2 events: press `1C`, then release `1C`. Final `key_down`=0, `key_code`=`1C`, `press_count`=1. Exactly 3 pop pulses.
- Bytes `1B 1B 1B F0 1B` (typematic) → exactly 2 events: press `1B`, release `1B`. `press_count`=1 and 5 pops.
- Bytes `E0 75 E0 F0 75` → press `75` ext=1, then release `75` ext=1. Also `key_ext`=1. No event for any prefix byte.
- Bytes `1C 32 F0 1C` → press `1C`, press `32` (`press_count`=2, `key_code`=`32`), release `1C` with `key_down` still 1. Pulse `kbd_overflow` for one cycle → `err_overflow`=1 until `clrn`.
- Byte `F0` consumed, then `clrn` low for 1 cycle, then byte `1C` → event is a press (break=0), since the pending prefix was cleared by reset. `press_count`=1.
